sid_regfile: RTL
================

# sid_regfile

Register file and bus responder feeding per-voice register structs to the three `sid_waveform` instances. Decodes CPU bus cycles into voice, envelope, and filter registers, and returns read data. Read-back covers POTX/POTY, OSC3 and ENV3. Write-only and unused addresses return a decaying bus-latch value.

## Interface

Parameters:
- `DECAY_6581`, default `'h01D00`: bus-latch lifetime in SID cycles for the 6581.
- `DECAY_8580`, default `'hA2000`: bus-latch lifetime in SID cycles for the 8580.

Ports:
- `clk  in  1`: system clock. This is the only clock.
- `res  in  1`: synchronous, active-high reset.
- `model  in  sid::model_e`: chip model; selects the decay lifetime.
- `phase  in  sid::phase_t`: SID cycle phase one-hot.
- `bus_i  in  sid::bus_i_t`: bus cycle, fields `cs` (active high), `rw` (1 = read), `addr[4:0]`, `data[7:0]`.
- `pot_x, pot_y, osc3, env3  in  8 each`: readable register sources.
- `reg_o  out  sid::waveform_reg_t [3]`: voice waveform registers.
- `env_o  out  sid::envelope_reg_t [3]`: attack, decay, sustain, release and gate, per voice.
- `filt_o  out  sid::filter_reg_t`: `fc[10:0]`, `res[3:0]`, `filt[3:0]`, `mode[3:0]`, `vol[3:0]`.
- `data_o  out  8`: read data.

## Operation

Register map:
- Voice n (n = 0..2), base `7n`:
  - +0 `freq_lo`, +1 `freq_hi`, +2 `pw_lo`, +3 `pw_hi[3:0]`.
  - +4 control: bits 7..0 = noise, pulse, sawtooth, triangle, test, ring_mod, sync, gate.
  - +5 attack/decay, +6 sustain/release.
- Filter and volume:
  - `'h15` `fc[2:0]`; `'h16` `fc[10:3]`.
  - `'h17` res/filt; `'h18` mode/vol.
- Read-only: `'h19` pot_x, `'h1A` pot_y, `'h1B` osc3, `'h1C` env3. Writes to these are ignored for register state but still load the bus latch.
- `'h1D`–`'h1F`: unused.

Bus cycle sampling and writes:
- A bus cycle is sampled only when `phase[sid::PHI2] & bus_i.cs`.
- Write (`rw = 0`): update the addressed register bits. Unimplemented bits (`pw_hi[7:4]`, `'h15[7:3]`) are discarded.

Bus latch:
- `bus_latch` is 8 bits. A decay counter `dcnt` (20 bits) works alongside it.
- Any sampled bus cycle sets `dcnt` to `model == MOS6581 ? DECAY_6581 : DECAY_8580`.
- On a write, `bus_latch` is loaded with `bus_i.data`.
- On a read of `'h19`–`'h1C`, `bus_latch` is loaded with the returned value.
- On a read of any other address, `bus_latch` is left unchanged.
- Otherwise, `dcnt` decrements once per `phase[sid::PHI2]` while nonzero. On the 1→0 transition, `bus_latch` is cleared to 0.

Read data:
- `data_o` is updated only on a sampled read, and holds until the next sampled read.
- Value returned: the source for `'h19`–`'h1C`; `bus_latch` for all other addresses.

## Timing

- Reset clears everything to 0: every `reg_o`, `env_o`, `filt_o` field, `data_o`, `bus_latch` and `dcnt`.
- Reset takes priority over a simultaneous bus cycle.
- Write latency:
  - The register is updated on the `clk` edge ending the `PHI2` phase.
  - `sid_waveform` consumes it from the following `PHI1`. This gives one SID cycle from bus write to oscillator effect.
- Read latency: `data_o` is valid on the edge ending `PHI2`. It is sampled by the bus interface before the next `PHI2`.
- Read sources are sampled combinationally in that same `PHI2` phase.
- Boundary conditions:
  - Bus cycle and decay expiry in the same cycle: the bus cycle wins. The latch is reloaded, not cleared.
  - `model` change: affects only the next `dcnt` load.
  - `dcnt == 0` with no access: the latch stays 0 and there is no wrap.
  - `cs` asserted outside `PHI2`: ignored.
  - Back-to-back writes to the same address in consecutive SID cycles: each takes effect, and the last value wins.

## Structure

- Package `sid` gains:
  - types `bus_i_t`, `envelope_reg_t`, `filter_reg_t`;
  - register address constants `REG_FREQ_LO`…`REG_ENV3`.
- `waveform_reg_t` is reused unchanged.
- One sub-module, `sid_bus_latch`: holds the latch, `dcnt`, the model-dependent reload, and the expiry clear.
- Address decode and registers stay in `sid_regfile`.

## Test plan

- Reset, then read `'h00`: `data_o = 0`, and all of `reg_o`, `env_o` and `filt_o` are 0.
- Write `'h0B` = `'hFF` (voice 1 control): `reg_o[1]` has noise, pulse, sawtooth, triangle, test, ring_mod and sync all set; `env_o[1].gate = 1`; voice 0 and voice 2 are unchanged.
- Write `'h03` = `'hA5`: `reg_o[0].pw_hi = 'h5`. A subsequent read of `'h03` returns `'hA5`, the bus latch.
- 6581, write `'h05` = `'h3C`, then idle: a read after `'h01CFF` SID cycles returns `'h3C`. The read itself reloads `dcnt`.
- 6581, write `'h05` = `'h3C`, then idle without reading: after `'h01D00` SID cycles, a read returns 0. Repeat with the 8580 using `'hA2000`.
- `osc3 = 'h7E`, read `'h1B`: returns `'h7E`. Then read `'h1E` two SID cycles later: returns `'h7E` via the latch.
- Assert `res` during a `PHI2` write: the register stays 0 and `data_o = 0`.

Source files
------------

// File: rtl/sid_regfile_pkg.sv
// Shared SID types: chip model, phase, bus cycle and per-block register structs.
package sid;

  typedef enum logic {
    MOS6581 = 1'b0,
    MOS8580 = 1'b1
  } model_e;

  localparam int unsigned NUM_PHASES = 2;
  localparam int unsigned PHI1       = 0;
  localparam int unsigned PHI2       = 1;
  typedef logic [NUM_PHASES-1:0] phase_t;

  localparam int unsigned NUM_VOICES   = 3;
  localparam int unsigned VOICE_STRIDE = 7;

  typedef struct packed {
    logic       cs;
    logic       rw;
    logic [4:0] addr;
    logic [7:0] data;
  } bus_i_t;

  typedef struct packed {
    logic [15:0] freq;
    logic [11:0] pw;
    logic        noise;
    logic        pulse;
    logic        sawtooth;
    logic        triangle;
    logic        test;
    logic        ring_mod;
    logic        sync;
  } waveform_reg_t;

  // 'rel' holds the release rate ('release' is a reserved word).
  typedef struct packed {
    logic [3:0] attack;
    logic [3:0] decay;
    logic [3:0] sustain;
    logic [3:0] rel;
    logic       gate;
  } envelope_reg_t;

  typedef struct packed {
    logic [10:0] fc;
    logic [3:0]  res;
    logic [3:0]  filt;
    logic [3:0]  mode;
    logic [3:0]  vol;
  } filter_reg_t;

  // Per-voice register offsets from the voice base.
  localparam logic [4:0] REG_FREQ_LO  = 5'h00;
  localparam logic [4:0] REG_FREQ_HI  = 5'h01;
  localparam logic [4:0] REG_PW_LO    = 5'h02;
  localparam logic [4:0] REG_PW_HI    = 5'h03;
  localparam logic [4:0] REG_CTRL     = 5'h04;
  localparam logic [4:0] REG_AD       = 5'h05;
  localparam logic [4:0] REG_SR       = 5'h06;
  // Absolute filter / volume / read-only addresses.
  localparam logic [4:0] REG_FC_LO    = 5'h15;
  localparam logic [4:0] REG_FC_HI    = 5'h16;
  localparam logic [4:0] REG_RES_FILT = 5'h17;
  localparam logic [4:0] REG_MODE_VOL = 5'h18;
  localparam logic [4:0] REG_POTX     = 5'h19;
  localparam logic [4:0] REG_POTY     = 5'h1A;
  localparam logic [4:0] REG_OSC3     = 5'h1B;
  localparam logic [4:0] REG_ENV3     = 5'h1C;

  function automatic logic [4:0] voice_addr(input int unsigned v, input logic [4:0] off);
    return 5'(v * VOICE_STRIDE) + off;
  endfunction

endpackage

// File: rtl/sid_regfile_bus_latch.sv
// Decaying bus latch: holds the last bus value and clears it after a model-dependent lifetime.
module sid_bus_latch
  import sid::*;
#(
  parameter logic [19:0] DECAY_6581 = 20'h01D00,
  parameter logic [19:0] DECAY_8580 = 20'hA2000
) (
  input  logic       clk,
  input  logic       res,
  input  model_e     model,
  input  logic       tick,
  input  logic       access,
  input  logic       load,
  input  logic [7:0] load_data,
  output logic [7:0] latch
);

  logic [19:0] dcnt;

  // Any access reloads the lifetime and wins over a same-cycle expiry.
  always_ff @(posedge clk) begin
    if (res) begin
      dcnt  <= '0;
      latch <= '0;
    end else if (access) begin
      dcnt <= (model == MOS6581) ? DECAY_6581 : DECAY_8580;
      if (load) latch <= load_data;
    end else if (tick && dcnt != '0) begin
      dcnt <= dcnt - 20'd1;
      if (dcnt == 20'd1) latch <= '0;
    end
  end

endmodule

// File: rtl/sid_regfile.sv
// SID register file: decodes bus writes into voice/envelope/filter registers and serves reads.
module sid_regfile
  import sid::*;
#(
  parameter logic [19:0] DECAY_6581 = 20'h01D00,
  parameter logic [19:0] DECAY_8580 = 20'hA2000
) (
  input  logic          clk,
  input  logic          res,
  input  model_e        model,
  input  phase_t        phase,
  input  bus_i_t        bus_i,
  input  logic [7:0]    pot_x,
  input  logic [7:0]    pot_y,
  input  logic [7:0]    osc3,
  input  logic [7:0]    env3,
  output waveform_reg_t reg_o  [NUM_VOICES],
  output envelope_reg_t env_o  [NUM_VOICES],
  output filter_reg_t   filt_o,
  output logic [7:0]    data_o
);

  waveform_reg_t wave_q [NUM_VOICES];
  envelope_reg_t env_q  [NUM_VOICES];
  filter_reg_t   filt_q;
  logic [7:0]    data_q;
  logic [7:0]    latch;

  logic          sample;
  logic          wr;
  logic          rd;
  logic          ro_hit;
  logic [7:0]    ro_data;

  assign sample = phase[PHI2] & bus_i.cs;
  assign wr     = sample & ~bus_i.rw;
  assign rd     = sample & bus_i.rw;

  // Read-only sources are selected combinationally during the PHI2 phase.
  always_comb begin
    ro_hit  = 1'b1;
    ro_data = '0;
    case (bus_i.addr)
      REG_POTX: ro_data = pot_x;
      REG_POTY: ro_data = pot_y;
      REG_OSC3: ro_data = osc3;
      REG_ENV3: ro_data = env3;
      default:  ro_hit  = 1'b0;
    endcase
  end

  sid_bus_latch #(
    .DECAY_6581(DECAY_6581),
    .DECAY_8580(DECAY_8580)
  ) u_bus_latch (
    .clk      (clk),
    .res      (res),
    .model    (model),
    .tick     (phase[PHI2]),
    .access   (sample),
    .load     (wr | (rd & ro_hit)),
    .load_data(wr ? bus_i.data : ro_data),
    .latch    (latch)
  );

  // Register writes; unimplemented bits are dropped at decode.
  always_ff @(posedge clk) begin
    if (res) begin
      for (int unsigned v = 0; v < NUM_VOICES; v++) begin
        wave_q[v] <= '0;
        env_q[v]  <= '0;
      end
      filt_q <= '0;
    end else if (wr) begin
      for (int unsigned v = 0; v < NUM_VOICES; v++) begin
        if (bus_i.addr == voice_addr(v, REG_FREQ_LO)) wave_q[v].freq[7:0]  <= bus_i.data;
        if (bus_i.addr == voice_addr(v, REG_FREQ_HI)) wave_q[v].freq[15:8] <= bus_i.data;
        if (bus_i.addr == voice_addr(v, REG_PW_LO))   wave_q[v].pw[7:0]    <= bus_i.data;
        if (bus_i.addr == voice_addr(v, REG_PW_HI))   wave_q[v].pw[11:8]   <= bus_i.data[3:0];
        if (bus_i.addr == voice_addr(v, REG_CTRL))
          {wave_q[v].noise, wave_q[v].pulse, wave_q[v].sawtooth, wave_q[v].triangle,
           wave_q[v].test, wave_q[v].ring_mod, wave_q[v].sync, env_q[v].gate} <= bus_i.data;
        if (bus_i.addr == voice_addr(v, REG_AD))
          {env_q[v].attack, env_q[v].decay} <= bus_i.data;
        if (bus_i.addr == voice_addr(v, REG_SR))
          {env_q[v].sustain, env_q[v].rel} <= bus_i.data;
      end
      case (bus_i.addr)
        REG_FC_LO:    filt_q.fc[2:0]              <= bus_i.data[2:0];
        REG_FC_HI:    filt_q.fc[10:3]             <= bus_i.data;
        REG_RES_FILT: {filt_q.res, filt_q.filt}   <= bus_i.data;
        REG_MODE_VOL: {filt_q.mode, filt_q.vol}   <= bus_i.data;
        default:      ;
      endcase
    end
  end

  // Read data register: updated only on sampled reads, held otherwise.
  always_ff @(posedge clk) begin
    if (res)     data_q <= '0;
    else if (rd) data_q <= ro_hit ? ro_data : latch;
  end

  assign reg_o  = wave_q;
  assign env_o  = env_q;
  assign filt_o = filt_q;
  assign data_o = data_q;

endmodule
